// File: rtl/ex_ctrl_unit.sv
// ex_ctrl_unit: registered execute-stage control decode plus a mult/div
// launch/wait sequencer with a timeout watchdog.
// Optional feature macro: EX_CTRL_MULDIV_EN. When defined, R-type mul/div
// (opcode 00000, alu_op 00110/00111) are launched through md_start and the
// unit waits for md_ready or the watchdog. When undefined, mul/div decode
// as ordinary R-type ops and the multdiv handshake pins are tied off.
module ex_ctrl_unit #(
   parameter int ALU_OPW    = 5,
   parameter int MD_TIMEOUT = 40
) (
   input  logic               clock,
   input  logic               reset_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [4:0]         opcode,
   input  logic [ALU_OPW-1:0] alu_op,
   input  logic               flush,
   output logic               out_valid,
   output logic               alu_op_choice,
   output logic               alu_in_B,
   output logic               j_alpha,
   output logic               j_beta,
   output logic               alu_addsub,
   output logic [ALU_OPW-1:0] alu_op_out,
   output logic               md_start,
   output logic               md_is_div,
   input  logic               md_ready,
   output logic               md_err
);

   // Decoded control bundle, loaded only on accept and held otherwise.
   typedef struct packed {
      logic               op_choice;
      logic               in_b;
      logic               j_a;
      logic               j_b;
      logic               addsub;
      logic [ALU_OPW-1:0] aluop;
   } ctrl_t;

   // Opcode decode; anything not listed yields an all-zero bundle.
   function automatic ctrl_t decode(input logic [4:0] opc, input logic [ALU_OPW-1:0] fn);
      ctrl_t c;
      c = '0;
      case (opc)
         5'b00000: c.aluop = fn;
         5'b00101, 5'b00111, 5'b01000: begin
            c.in_b      = 1'b1;
            c.op_choice = 1'b1;
         end
         5'b00010: begin
            c.op_choice = 1'b1;
            c.addsub    = 1'b1;
            c.aluop     = ALU_OPW'(1);
         end
         5'b00110: begin
            c.addsub = 1'b1;
            c.aluop  = ALU_OPW'(1);
         end
         5'b00001, 5'b00011, 5'b10110: begin
            c.j_a = 1'b1;
            c.j_b = 1'b1;
         end
         5'b00100: c.j_a = 1'b1;
         default: c = '0;
      endcase
      return c;
   endfunction

   ctrl_t ctrl_q, ctrl_d;
   logic  vld_q, vld_d;
   logic  start_q, start_d;
   logic  div_q, div_d;
   logic  err_q, err_d;
   logic  accept;

`ifdef EX_CTRL_MULDIV_EN
   localparam int CNTW = $clog2(MD_TIMEOUT + 1);

   typedef enum logic [0:0] {IDLE, MD_WAIT} state_t;

   state_t          state_q, state_d;
   logic [CNTW-1:0] cnt_q, cnt_d;
   logic            is_md;

   assign in_ready = (state_q == IDLE);
   assign accept   = in_valid & in_ready & ~flush;
   assign is_md    = (opcode == 5'b00000) &&
                     ((alu_op == ALU_OPW'(6)) || (alu_op == ALU_OPW'(7)));

   // Next-state: launch mult/div on accept, then wait for ready, timeout or flush.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      ctrl_d  = ctrl_q;
      div_d   = div_q;
      vld_d   = 1'b0;
      start_d = 1'b0;
      err_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (accept) begin
               ctrl_d = decode(opcode, alu_op);
               div_d  = is_md & (alu_op == ALU_OPW'(7));
               if (is_md) begin
                  start_d = 1'b1;
                  cnt_d   = '0;
                  state_d = MD_WAIT;
               end else begin
                  vld_d = 1'b1;
               end
            end
         end
         MD_WAIT: begin
            // Flush wins over both completion paths; md_ready wins over timeout.
            if (flush) begin
               cnt_d   = '0;
               state_d = IDLE;
            end else if (md_ready) begin
               vld_d   = 1'b1;
               cnt_d   = '0;
               state_d = IDLE;
            end else if (cnt_q == CNTW'(MD_TIMEOUT - 1)) begin
               vld_d   = 1'b1;
               err_d   = 1'b1;
               cnt_d   = '0;
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            cnt_d   = '0;
            state_d = IDLE;
         end
      endcase
   end
`else
   logic unused_md_ready;

   assign unused_md_ready = md_ready;
   assign in_ready        = 1'b1;
   assign accept          = in_valid & ~flush;

   // Plain registered decode; mul/div are ordinary R-type ops here.
   always_comb begin
      ctrl_d  = ctrl_q;
      vld_d   = accept;
      start_d = 1'b0;
      div_d   = 1'b0;
      err_d   = 1'b0;
      if (accept) ctrl_d = decode(opcode, alu_op);
   end
`endif

   // All state and registered outputs.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
`ifdef EX_CTRL_MULDIV_EN
         state_q <= IDLE;
         cnt_q   <= '0;
`endif
         ctrl_q  <= '0;
         vld_q   <= 1'b0;
         start_q <= 1'b0;
         div_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
`ifdef EX_CTRL_MULDIV_EN
         state_q <= state_d;
         cnt_q   <= cnt_d;
`endif
         ctrl_q  <= ctrl_d;
         vld_q   <= vld_d;
         start_q <= start_d;
         div_q   <= div_d;
         err_q   <= err_d;
      end
   end

   assign out_valid     = vld_q;
   assign alu_op_choice = ctrl_q.op_choice;
   assign alu_in_B      = ctrl_q.in_b;
   assign j_alpha       = ctrl_q.j_a;
   assign j_beta        = ctrl_q.j_b;
   assign alu_addsub    = ctrl_q.addsub;
   assign alu_op_out    = ctrl_q.aluop;
   assign md_start      = start_q;
   assign md_is_div     = div_q;
   assign md_err        = err_q;

endmodule

// File: tb/tb_ex_ctrl_unit.sv
// Directed bench for ex_ctrl_unit. Mult/div sequencing checks run only when
// EX_CTRL_MULDIV_EN is defined; otherwise mul/div are checked as R-type ops.
module tb_ex_ctrl_unit;

   localparam int ALU_OPW    = 5;
   localparam int MD_TIMEOUT = 8;

   logic               clock = 1'b0;
   logic               reset_n = 1'b1;
   logic               in_valid = 1'b0;
   logic               in_ready;
   logic [4:0]         opcode = '0;
   logic [ALU_OPW-1:0] alu_op = '0;
   logic               flush = 1'b0;
   logic               out_valid;
   logic               alu_op_choice, alu_in_B, j_alpha, j_beta, alu_addsub;
   logic [ALU_OPW-1:0] alu_op_out;
   logic               md_start, md_is_div, md_ready = 1'b0, md_err;

   int n_vec = 0;
   int n_err = 0;

   ex_ctrl_unit #(.ALU_OPW(ALU_OPW), .MD_TIMEOUT(MD_TIMEOUT)) dut (
      .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
      .opcode(opcode), .alu_op(alu_op), .flush(flush), .out_valid(out_valid),
      .alu_op_choice(alu_op_choice), .alu_in_B(alu_in_B), .j_alpha(j_alpha),
      .j_beta(j_beta), .alu_addsub(alu_addsub), .alu_op_out(alu_op_out),
      .md_start(md_start), .md_is_div(md_is_div), .md_ready(md_ready), .md_err(md_err)
   );

   always #5 clock = ~clock;

   // {out_valid, alu_op_choice, alu_in_B, j_alpha, j_beta, alu_addsub, alu_op_out}
   logic [10:0] ctl_w;
   // {in_ready, md_start, md_is_div, md_err}
   logic [3:0]  md_w;
   assign ctl_w = {out_valid, alu_op_choice, alu_in_B, j_alpha, j_beta, alu_addsub, alu_op_out};
   assign md_w  = {in_ready, md_start, md_is_div, md_err};

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic drive(input logic v, input logic [4:0] opc, input logic [ALU_OPW-1:0] fn);
      in_valid = v;
      opcode   = opc;
      alu_op   = fn;
   endtask

   initial begin
      // Reset state
      #2 reset_n = 1'b0;
      #1;
      chk("reset_ctl", ctl_w, 11'b0_0_0_0_0_0_00000);
      chk("reset_md",  md_w,  4'b1_0_0_0);
      @(negedge clock);
      reset_n = 1'b1;
      step();
      chk("idle_ctl", ctl_w, 11'b0_0_0_0_0_0_00000);

      // addi then bne back-to-back
      drive(1'b1, 5'b00101, 5'b10101);
      step();
      chk("addi", ctl_w, 11'b1_1_1_0_0_0_00000);
      drive(1'b1, 5'b00010, 5'b01010);
      step();
      chk("bne", ctl_w, 11'b1_1_0_0_0_1_00001);
      drive(1'b0, 5'b00000, 5'b00000);
      step();
      chk("hold_bne", ctl_w, 11'b0_1_0_0_0_1_00001);

      // jumps
      drive(1'b1, 5'b00011, 5'b00000);
      step();
      chk("jal", ctl_w, 11'b1_0_0_1_1_0_00000);
      drive(1'b1, 5'b00100, 5'b00000);
      step();
      chk("jr", ctl_w, 11'b1_0_0_1_0_0_00000);
      drive(1'b1, 5'b00110, 5'b00000);
      step();
      chk("blt", ctl_w, 11'b1_0_0_0_0_1_00001);
      drive(1'b1, 5'b10110, 5'b00000);
      step();
      chk("bex", ctl_w, 11'b1_0_0_1_1_0_00000);
      drive(1'b1, 5'b00111, 5'b00000);
      step();
      chk("sw", ctl_w, 11'b1_1_1_0_0_0_00000);
      drive(1'b1, 5'b01000, 5'b11111);
      step();
      chk("lw", ctl_w, 11'b1_1_1_0_0_0_00000);
      drive(1'b1, 5'b00000, 5'b00011);
      step();
      chk("rtype", ctl_w, 11'b1_0_0_0_0_0_00011);
      drive(1'b1, 5'b11111, 5'b00011);
      step();
      chk("unknown", ctl_w, 11'b1_0_0_0_0_0_00000);

      // flush blocks acceptance, next cycle accepts
      drive(1'b1, 5'b00101, 5'b00000);
      flush = 1'b1;
      step();
      chk("flush_blk", ctl_w, 11'b0_0_0_0_0_0_00000);
      flush = 1'b0;
      step();
      chk("post_flush", ctl_w, 11'b1_1_1_0_0_0_00000);

      // md_ready in IDLE is ignored
      drive(1'b0, 5'b00000, 5'b00000);
      md_ready = 1'b1;
      step();
      chk("rdy_idle_ctl", ctl_w, 11'b0_1_1_0_0_0_00000);
      chk("rdy_idle_md",  md_w,  4'b1_0_0_0);
      md_ready = 1'b0;

`ifdef EX_CTRL_MULDIV_EN
      // mul, md_ready five cycles after md_start
      drive(1'b1, 5'b00000, 5'b00110);
      step();
      drive(1'b0, 5'b00000, 5'b00000);
      chk("mul_start_md",  md_w,        4'b0_1_0_0);
      chk("mul_start_vld", 16'(out_valid), 16'd0);
      for (int k = 1; k <= 5; k++) begin
         step();
         chk($sformatf("mul_wait%0d_md", k), md_w, 4'b0_0_0_0);
         chk($sformatf("mul_wait%0d_vld", k), 16'(out_valid), 16'd0);
      end
      md_ready = 1'b1;
      step();
      md_ready = 1'b0;
      chk("mul_done_ctl", ctl_w, 11'b1_0_0_0_0_0_00110);
      chk("mul_done_md",  md_w,  4'b1_0_0_0);
      step();
      chk("mul_after", ctl_w, 11'b0_0_0_0_0_0_00110);

      // div, md_ready never: timeout after MD_TIMEOUT wait cycles
      drive(1'b1, 5'b00000, 5'b00111);
      step();
      drive(1'b0, 5'b00000, 5'b00000);
      chk("div_start_md", md_w, 4'b0_1_1_0);
      for (int k = 1; k < MD_TIMEOUT; k++) begin
         step();
         chk($sformatf("div_wait%0d", k), {out_valid, md_w}, 5'b0_0_0_1_0);
      end
      step();
      chk("div_to_ctl", ctl_w, 11'b1_0_0_0_0_0_00111);
      chk("div_to_md",  md_w,  4'b1_0_1_1);
      step();
      chk("div_after", {out_valid, md_w}, 5'b0_1_0_1_0);

      // flush together with md_ready
      drive(1'b1, 5'b00000, 5'b00110);
      step();
      drive(1'b0, 5'b00000, 5'b00000);
      step();
      md_ready = 1'b1;
      flush    = 1'b1;
      step();
      md_ready = 1'b0;
      flush    = 1'b0;
      chk("flush_md", {out_valid, md_w}, 5'b0_1_0_0_0);
      drive(1'b1, 5'b00101, 5'b00000);
      step();
      drive(1'b0, 5'b00000, 5'b00000);
      chk("flush_addi", ctl_w, 11'b1_1_1_0_0_0_00000);

      // reset in the middle of MD_WAIT
      drive(1'b1, 5'b00000, 5'b00111);
      step();
      drive(1'b0, 5'b00000, 5'b00000);
      step();
      #2 reset_n = 1'b0;
      #1;
      chk("rst_mid_ctl", ctl_w, 11'b0_0_0_0_0_0_00000);
      chk("rst_mid_md",  md_w,  4'b1_0_0_0);
      reset_n = 1'b1;
      for (int k = 0; k < 3; k++) begin
         step();
         chk($sformatf("rst_post%0d", k), {out_valid, md_w}, 5'b0_1_0_0_0);
      end
`else
      // mul/div as plain R-type ops
      drive(1'b1, 5'b00000, 5'b00110);
      step();
      chk("mul_rtype_ctl", ctl_w, 11'b1_0_0_0_0_0_00110);
      chk("mul_rtype_md",  md_w,  4'b1_0_0_0);
      drive(1'b1, 5'b00000, 5'b00111);
      md_ready = 1'b1;
      step();
      md_ready = 1'b0;
      chk("div_rtype_ctl", ctl_w, 11'b1_0_0_0_0_0_00111);
      chk("div_rtype_md",  md_w,  4'b1_0_0_0);
      drive(1'b0, 5'b00000, 5'b00000);
      step();
      chk("rtype_idle", ctl_w, 11'b0_0_0_0_0_0_00111);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/ex_ctrl_unit.md
# ex_ctrl_unit

Registered execute-stage control unit for the 5-bit-opcode processor pipeline. It decodes the D/X opcode into the X-stage ALU and jump-select controls one cycle after acceptance. It also sequences multi-cycle multiply/divide operations through a start/ready handshake with a timeout watchdog. It sits between the D/X pipeline latch and the ALU, multdiv unit and PC-select logic, and back-pressures decode while a mult/div is outstanding.

## Interface
Parameters:
- ALU_OPW, 5, width of the R-type ALU function field.
- MD_TIMEOUT, 40, maximum MD_WAIT cycles before a mult/div is abandoned (≥2).

Ports:
- clock  in  1  pipeline clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  D/X latch holds an instruction.
- in_ready  out  1  unit can accept; equals (state==IDLE).
- opcode  in  5  instruction opcode.
- alu_op  in  ALU_OPW  R-type function field.
- flush  in  1  branch/jump squash from PC logic.
- out_valid  out  1  registered controls are valid this cycle.
- alu_op_choice, alu_in_B, j_alpha, j_beta, alu_addsub  out  1 each  registered decoded controls.
- alu_op_out  out  ALU_OPW  registered ALU function.
- md_start  out  1  one-cycle launch pulse to multdiv.
- md_is_div  out  1  launched op is divide, held through MD_WAIT.
- md_ready  in  1  multdiv result ready.
- md_err  out  1  qualifies out_valid: mult/div timed out.

## Operation
- Decode, registered on accept (in_valid & in_ready), all other opcodes give all-zero:
  - alu_in_B: 00101 addi, 00111 sw, 01000 lw.
  - alu_op_choice: the alu_in_B set plus 00010 bne.
  - alu_addsub: 00010 bne, 00110 blt.
  - j_alpha: 00001 j, 00011 jal, 00100 jr, 10110 bex.
  - j_beta: 00001, 00011, 10110.
- alu_op_out: alu_op for opcode 00000; 00000 for add-type immediates; 00001 for bne/blt.
- FSM states:
  - IDLE: on accept of a non-mult/div op → out_valid=1 next cycle, stay in IDLE.
  - On accept of 00000 with alu_op 00110 (mul) or 00111 (div) → md_start=1 next cycle, md_is_div latched, go to MD_WAIT; out_valid stays 0.
  - MD_WAIT: counter increments each cycle. md_ready=1 → out_valid=1 (md_err=0) next cycle, go to IDLE. Counter reaches MD_TIMEOUT without md_ready → out_valid=1, md_err=1 next cycle, go to IDLE.
- flush: clears out_valid next cycle, blocks acceptance that cycle, forces MD_WAIT→IDLE without an out_valid pulse. Flush beats md_ready and timeout when simultaneous.
- md_ready while in IDLE is ignored.
- Reset (async, any time): state IDLE, counter 0; all outputs 0 except in_ready=1.

## Timing
- Non-mult/div latency: accept in cycle T → out_valid and controls in T+1, one cycle wide. Back-to-back accepts give out_valid every cycle.
- Mult/div: accept at T → md_start at T+1 only. md_ready sampled from T+1. md_ready at R → out_valid at R+1; in_ready returns at R+1.
- Timeout: md_ready absent through MD_TIMEOUT consecutive MD_WAIT cycles → out_valid+md_err in the following cycle.
- Controls hold their last value when out_valid=0; consumers qualify with out_valid.
- Counter width $clog2(MD_TIMEOUT+1); no wrap possible.

## Configuration
- EX_CTRL_MULDIV_EN defined: mult/div FSM path as above.
- Undefined: mul/div decode as ordinary R-type. out_valid at T+1, md_start/md_is_div/md_err tied 0, md_ready ignored, in_ready constant 1.

## Test plan
- Reset mid-MD_WAIT → all outputs 0, in_ready=1 immediately, no md_start afterwards.
- addi (00101) then bne (00010) back-to-back → T+1: alu_in_B=1, alu_op_choice=1. T+2: alu_op_choice=1, alu_addsub=1, alu_op_out=00001.
- jal (00011) and jr (00100) → j_alpha=1/j_beta=1, then j_alpha=1/j_beta=0, others 0.
- mul, md_ready 5 cycles after md_start → md_start single pulse, in_ready=0 throughout, out_valid one cycle after md_ready, md_err=0.
- div, MD_TIMEOUT=4, md_ready never → out_valid=1, md_err=1, md_is_div=1 on 5th cycle after md_start.
- flush asserted same cycle as md_ready → no out_valid, state IDLE, next addi accepted normally.
